clint_timer: RTL and testbench
==============================

Name: clint_timer

Overview:
- Multi-hart core-local interruptor; parametrised successor of the single-hart machine timer.
- Holds one shared 64-bit mtime, one mtimecmp per hart, and one msip bit per hart.
- Sits on the CPU memory-mapped peripheral port next to the data-memory path.
- Drives registered timer and software interrupt lines into each hart's CSR/trap unit.

Parameters:
- NUM_HART, 2, number of harts; 1..8.
- TICK_DIV, 1, mtime increments once every TICK_DIV clk cycles; 1..65535.
- BASE_ADDR, 64'h0000_0000_0200_0000, base of the 64 KiB register window.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- i_valid  in  1  access request
- i_wen  in  1  1 = write, 0 = read
- i_addr  in  64  byte address; 8-byte aligned for mtime/mtimecmp, 4-byte aligned for msip
- i_wdata  in  64  write data, little-endian lanes
- i_wstrb  in  8  byte write enables
- o_rdata  out  64  read data, registered
- o_rvalid  out  1  read data valid, one cycle after an accepted read
- o_err  out  1  one-cycle pulse, one cycle after an access to an unmapped or misaligned address
- o_timer_int  out  NUM_HART  per-hart machine timer interrupt, registered
- o_soft_int  out  NUM_HART  per-hart machine software interrupt, registered

Behaviour:
- Address map (offsets from BASE_ADDR):
  - msip[h] at 0x0000 + 4h; bit 0 only; other bits read 0.
  - mtimecmp[h] at 0x4000 + 8h.
  - mtime at 0xBFF8.
  - All other addresses are unmapped.
- Reset state:
  - mtime = 0, prescaler = 0, every mtimecmp = 64'hFFFF_FFFF_FFFF_FFFF, every msip = 0.
  - o_rdata = 0, o_rvalid = 0, o_err = 0, o_timer_int = 0, o_soft_int = 0.
- Accepting requests:
  - Always ready; a request is accepted in any cycle with i_valid = 1.
  - Back-to-back accesses are allowed every cycle.
- Prescaler:
  - Counts 0..TICK_DIV-1.
  - On the wrap cycle it returns to 0 and mtime increments by 1.
  - With TICK_DIV = 1, mtime increments every cycle.
  - mtime wraps from 2^64-1 to 0 with no flag.
- Writes:
  - Byte-merge: only lanes with i_wstrb[b] = 1 update.
  - For msip, i_addr[2] selects the 32-bit lane; only bit 0 of that word is stored.
  - A write to mtime takes priority over the increment in that cycle, and the prescaler is cleared to 0.
  - A write to mtimecmp[h] takes effect at the next clock edge.
- Reads:
  - o_rdata is captured from register state before any same-cycle write; o_rvalid = 1 for one cycle.
  - For msip, data is returned in the lane selected by i_addr[2].
  - An unmapped read returns o_rdata = 0 with o_rvalid = 1.
  - o_rdata holds its value when no read is in flight.
- Errors:
  - Unmapped or misaligned access: writes have no effect, and o_err pulses one cycle later.
  - A read also gets o_rvalid with o_rdata = 0.
- Interrupts:
  - o_timer_int[h] <= (mtime_q >= mtimecmp_q[h]), unsigned compare of register values. One cycle latency from a register update to the output.
  - o_soft_int[h] <= msip[h]; one cycle latency.
- Reset mid-operation: all state returns to reset values at the next edge; an in-flight read's o_rvalid is dropped.

Decomposition:
- Shared package: offset constants MSIP_OFF, MTIMECMP_OFF, MTIME_OFF; window size 0x10000; hart stride constants; mtimecmp reset value.
- One natural sub-module: clint_prescaler, holding the TICK_DIV counter and emitting a tick pulse.
- Register file, address decode and compare logic stay in clint_timer.

Test Plan:
- Reset release, TICK_DIV = 1:
  - Read mtime at the fifth cycle after reset release -> o_rdata = 4, o_rvalid = 1 one cycle later.
  - o_timer_int = 0.
- mtimecmp[1] = 20, TICK_DIV = 4:
  - mtime reaches 20 at the 80th tick-domain cycle -> o_timer_int[1] rises exactly one cycle after mtime_q = 20.
  - o_timer_int[0] stays 0.
- Write mtime = 64'hFFFF_FFFF_FFFF_FFFE, TICK_DIV = 1:
  - Two cycles later mtime = 0 (wrap).
  - Any hart with mtimecmp = 64'hFFFF_FFFF_FFFF_FFFF: o_timer_int drops after the wrap.
- Write msip[1] with i_wdata = 64'h1_0000_0000, i_wstrb = 8'hF0 at offset 0x0004:
  - o_soft_int[1] = 1 one cycle after the write edge.
  - Readback returns bit 32 set.
- Partial write with i_wstrb = 8'h0F, i_wdata = 64'h1234_5678, to mtimecmp[0] = 64'hAAAA_BBBB_CCCC_DDDD -> readback 64'hAAAA_BBBB_1234_5678.
- Simultaneous events and errors:
  - Same-cycle mtime write and prescaler wrap -> mtime equals the written value, and the prescaler restarts at 0.
  - Read at offset 0x8000 -> o_rdata = 0, o_rvalid = 1, o_err = 1.

Source files
------------

// File: rtl/clint_timer_pkg.sv
// rtl/clint_timer_pkg.sv - register map constants and helpers shared by the CLINT timer block
package clint_timer_pkg;

  // Register offsets inside the CLINT window.
  localparam logic [15:0] MSIP_OFF     = 16'h0000;
  localparam logic [15:0] MTIMECMP_OFF = 16'h4000;
  localparam logic [15:0] MTIME_OFF    = 16'hBFF8;

  // The window is 64 KiB; anything outside it, or in a hole inside it, is unmapped.
  localparam logic [63:0] WINDOW_SIZE = 64'h0000_0000_0001_0000;

  // Per-hart register strides in bytes.
  localparam int MSIP_STRIDE     = 4;
  localparam int MTIMECMP_STRIDE = 8;

  // A comparator at all-ones never fires until mtime itself reaches all-ones.
  localparam logic [63:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF;

  // Replace only the byte lanes whose strobe is set.
  function automatic logic [63:0] byte_merge(input logic [63:0] old_val,
                                             input logic [63:0] new_val,
                                             input logic [7:0]  strb);
    logic [63:0] res;
    res = old_val;
    for (int b = 0; b < 8; b++) begin
      if (strb[b]) res[8*b +: 8] = new_val[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/clint_prescaler.sv
// rtl/clint_prescaler.sv - divides clk by TICK_DIV to pace mtime increments
//   clk, rst_n : clock, synchronous active-low reset
//   clr        : restart the count at 0 on the next edge
//   tick       : high in the cycle where the count wraps (always high when TICK_DIV = 1)
module clint_prescaler #(
  parameter int unsigned TICK_DIV = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);

  localparam logic [15:0] LAST = 16'(TICK_DIV - 1);

  logic [15:0] cnt_q;
  logic [15:0] cnt_d;

  assign tick = (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q + 16'd1;
    if (clr || tick) cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/clint_timer.sv
// rtl/clint_timer.sv - multi-hart core-local interruptor: mtime, per-hart mtimecmp and msip
//   clk, rst_n          : clock, synchronous active-low reset
//   i_valid/i_wen       : access request, 1 = write
//   i_addr/i_wdata      : byte address and little-endian write data
//   i_wstrb             : byte write enables
//   o_rdata/o_rvalid    : registered read data and its one-cycle valid
//   o_err               : one-cycle pulse after an unmapped or misaligned access
//   o_timer_int         : per-hart registered mtime >= mtimecmp
//   o_soft_int          : per-hart registered msip
module clint_timer
  import clint_timer_pkg::*;
#(
  parameter int unsigned NUM_HART  = 2,
  parameter int unsigned TICK_DIV  = 1,
  parameter logic [63:0] BASE_ADDR = 64'h0000_0000_0200_0000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_valid,
  input  logic                i_wen,
  input  logic [63:0]         i_addr,
  input  logic [63:0]         i_wdata,
  input  logic [7:0]          i_wstrb,
  output logic [63:0]         o_rdata,
  output logic                o_rvalid,
  output logic                o_err,
  output logic [NUM_HART-1:0] o_timer_int,
  output logic [NUM_HART-1:0] o_soft_int
);

  localparam logic [15:0] MSIP_SPAN = 16'(MSIP_STRIDE * NUM_HART);
  localparam logic [15:0] CMP_SPAN  = 16'(MTIMECMP_STRIDE * NUM_HART);

  logic [63:0]         mtime_q, mtime_d;
  logic [63:0]         cmp_q [NUM_HART];
  logic [63:0]         cmp_d [NUM_HART];
  logic [NUM_HART-1:0] msip_q, msip_d;
  logic [63:0]         rdata_q, rdata_d;
  logic                rvalid_q, rvalid_d;
  logic                err_q, err_d;
  logic [NUM_HART-1:0] timer_int_q, timer_int_d;
  logic [NUM_HART-1:0] soft_int_q, soft_int_d;

  logic [63:0] addr_diff;
  logic [15:0] off, msip_rel, cmp_rel;
  logic        in_win, msip_hit, cmp_hit, mtime_hit, hit;
  logic [2:0]  msip_idx, cmp_idx;
  logic        lane_hi;
  logic        msip_wbit, msip_wen;
  logic        wr_acc, rd_acc, mtime_we;
  logic        tick;
  logic [63:0] rd_word;

  // Subtracting the base first lets one unsigned compare reject addresses
  // both below and above the window.
  always_comb begin
    addr_diff = i_addr - BASE_ADDR;
    in_win    = addr_diff < WINDOW_SIZE;
    off       = addr_diff[15:0];
    msip_rel  = off - MSIP_OFF;
    cmp_rel   = off - MTIMECMP_OFF;
    msip_idx  = msip_rel[4:2];
    cmp_idx   = cmp_rel[5:3];
    msip_hit  = in_win && (msip_rel < MSIP_SPAN) && (msip_rel[1:0] == 2'b00);
    cmp_hit   = in_win && (cmp_rel < CMP_SPAN) && (cmp_rel[2:0] == 3'b000);
    mtime_hit = in_win && (off == MTIME_OFF);
    hit       = msip_hit || cmp_hit || mtime_hit;
    wr_acc    = i_valid && i_wen && hit;
    rd_acc    = i_valid && !i_wen;
    mtime_we  = wr_acc && mtime_hit;
    // msip words are 32 bits; address bit 2 picks which half of the 64-bit bus carries it.
    lane_hi   = i_addr[2];
    msip_wbit = lane_hi ? i_wdata[32] : i_wdata[0];
    msip_wen  = lane_hi ? i_wstrb[4]  : i_wstrb[0];
  end

  clint_prescaler #(
    .TICK_DIV(TICK_DIV)
  ) u_prescaler (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (mtime_we),
    .tick (tick)
  );

  // Read mux works off pre-write register state; unmapped reads fall through to 0.
  always_comb begin
    rd_word = '0;
    if (mtime_hit) rd_word = mtime_q;
    for (int h = 0; h < int'(NUM_HART); h++) begin
      if (cmp_hit && (cmp_idx == 3'(h))) rd_word = cmp_q[h];
      if (msip_hit && (msip_idx == 3'(h))) begin
        rd_word = lane_hi ? {31'b0, msip_q[h], 32'b0} : {63'b0, msip_q[h]};
      end
    end
  end

  always_comb begin
    mtime_d = mtime_q;
    if (mtime_we)  mtime_d = byte_merge(mtime_q, i_wdata, i_wstrb);
    else if (tick) mtime_d = mtime_q + 64'd1;

    msip_d = msip_q;
    for (int h = 0; h < int'(NUM_HART); h++) begin
      cmp_d[h] = cmp_q[h];
      if (wr_acc && cmp_hit && (cmp_idx == 3'(h))) begin
        cmp_d[h] = byte_merge(cmp_q[h], i_wdata, i_wstrb);
      end
      if (wr_acc && msip_hit && (msip_idx == 3'(h)) && msip_wen) begin
        msip_d[h] = msip_wbit;
      end
      timer_int_d[h] = (mtime_q >= cmp_q[h]);
    end
    soft_int_d = msip_q;

    rdata_d  = rd_acc ? rd_word : rdata_q;
    rvalid_d = rd_acc;
    err_d    = i_valid && !hit;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mtime_q     <= '0;
      msip_q      <= '0;
      rdata_q     <= '0;
      rvalid_q    <= 1'b0;
      err_q       <= 1'b0;
      timer_int_q <= '0;
      soft_int_q  <= '0;
      for (int h = 0; h < int'(NUM_HART); h++) cmp_q[h] <= MTIMECMP_RST;
    end else begin
      mtime_q     <= mtime_d;
      msip_q      <= msip_d;
      rdata_q     <= rdata_d;
      rvalid_q    <= rvalid_d;
      err_q       <= err_d;
      timer_int_q <= timer_int_d;
      soft_int_q  <= soft_int_d;
      for (int h = 0; h < int'(NUM_HART); h++) cmp_q[h] <= cmp_d[h];
    end
  end

  assign o_rdata     = rdata_q;
  assign o_rvalid    = rvalid_q;
  assign o_err       = err_q;
  assign o_timer_int = timer_int_q;
  assign o_soft_int  = soft_int_q;

endmodule

// File: tb/tb_clint_timer.sv
// tb/tb_clint_timer.sv - randomized and directed bench for clint_timer at TICK_DIV 1 and 4
module tb_clint_timer;

  localparam logic [63:0] BASE = 64'h0000_0000_0200_0000;
  localparam int NH = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, i_valid, i_wen;
  logic [63:0] i_addr, i_wdata;
  logic [7:0]  i_wstrb;

  logic [63:0] rdata_o [2];
  logic        rvalid_o [2];
  logic        err_o [2];
  logic [1:0]  tint_o [2];
  logic [1:0]  soft_o [2];

  clint_timer #(.NUM_HART(NH), .TICK_DIV(1), .BASE_ADDR(BASE)) u_dut_div1 (
    .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .i_wen(i_wen), .i_addr(i_addr),
    .i_wdata(i_wdata), .i_wstrb(i_wstrb), .o_rdata(rdata_o[0]), .o_rvalid(rvalid_o[0]),
    .o_err(err_o[0]), .o_timer_int(tint_o[0]), .o_soft_int(soft_o[0])
  );

  clint_timer #(.NUM_HART(NH), .TICK_DIV(4), .BASE_ADDR(BASE)) u_dut_div4 (
    .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .i_wen(i_wen), .i_addr(i_addr),
    .i_wdata(i_wdata), .i_wstrb(i_wstrb), .o_rdata(rdata_o[1]), .o_rvalid(rvalid_o[1]),
    .o_err(err_o[1]), .o_timer_int(tint_o[1]), .o_soft_int(soft_o[1])
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model: index 0 mirrors the TICK_DIV=1 instance, index 1 the TICK_DIV=4 one.
  int          div [2] = '{1, 4};
  logic [63:0] m_mtime [2];
  int          m_presc [2];
  logic [63:0] m_cmp [2][NH];
  bit          m_msip [2][NH];
  logic [63:0] e_rdata [2];
  bit          e_rvalid [2];
  bit          e_err [2];
  logic [1:0]  e_tint [2];
  logic [1:0]  e_soft [2];

  function automatic logic [63:0] merge(input logic [63:0] o, input logic [63:0] n,
                                        input logic [7:0] s);
    logic [63:0] r;
    r = o;
    for (int b = 0; b < 8; b++) if (s[b]) r[8*b +: 8] = n[8*b +: 8];
    return r;
  endfunction

  task automatic model_step();
    logic [63:0] d;
    int kind;
    int idx;
    int lane;
    bit wrote_mtime;
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        m_mtime[k] = '0; m_presc[k] = 0;
        for (int h = 0; h < NH; h++) begin m_cmp[k][h] = '1; m_msip[k][h] = 0; end
        e_rdata[k] = '0; e_rvalid[k] = 0; e_err[k] = 0; e_tint[k] = '0; e_soft[k] = '0;
        continue;
      end
      // kind: 0 unmapped, 1 msip, 2 mtimecmp, 3 mtime
      d = i_addr - BASE;
      kind = 0; idx = 0;
      if (d < 64'h10000) begin
        if (d % 4 == 0 && d / 4 < NH) begin kind = 1; idx = int'(d / 4); end
        else if (d >= 64'h4000 && d < 64'h4000 + 8 * NH && d % 8 == 0) begin
          kind = 2; idx = int'((d - 64'h4000) / 8);
        end else if (d == 64'hBFF8) kind = 3;
      end
      for (int h = 0; h < NH; h++) begin
        e_tint[k][h] = (m_mtime[k] >= m_cmp[k][h]);
        e_soft[k][h] = m_msip[k][h];
      end
      e_err[k]    = i_valid && (kind == 0);
      e_rvalid[k] = i_valid && !i_wen;
      lane = i_addr[2] ? 1 : 0;
      if (i_valid && !i_wen) begin
        case (kind)
          1:       e_rdata[k] = m_msip[k][idx] ? (64'h1 << (32 * lane)) : 64'h0;
          2:       e_rdata[k] = m_cmp[k][idx];
          3:       e_rdata[k] = m_mtime[k];
          default: e_rdata[k] = 64'h0;
        endcase
      end
      wrote_mtime = 0;
      if (i_valid && i_wen) begin
        case (kind)
          1: if (i_wstrb[4 * lane]) m_msip[k][idx] = i_wdata[32 * lane];
          2: m_cmp[k][idx] = merge(m_cmp[k][idx], i_wdata, i_wstrb);
          3: begin m_mtime[k] = merge(m_mtime[k], i_wdata, i_wstrb); wrote_mtime = 1; end
          default: ;
        endcase
      end
      if (wrote_mtime) m_presc[k] = 0;
      else begin
        m_presc[k]++;
        if (m_presc[k] == div[k]) begin m_presc[k] = 0; m_mtime[k]++; end
      end
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      check($sformatf("rdata[%0d]", k),  rdata_o[k],        e_rdata[k]);
      check($sformatf("rvalid[%0d]", k), 64'(rvalid_o[k]),  64'(e_rvalid[k]));
      check($sformatf("err[%0d]", k),    64'(err_o[k]),     64'(e_err[k]));
      check($sformatf("tint[%0d]", k),   64'(tint_o[k]),    64'(e_tint[k]));
      check($sformatf("soft[%0d]", k),   64'(soft_o[k]),    64'(e_soft[k]));
    end
  endtask

  task automatic set_idle();
    i_valid = 0; i_wen = 0; i_addr = BASE; i_wdata = '0; i_wstrb = '0;
  endtask

  task automatic set_rd(input logic [63:0] off);
    i_valid = 1; i_wen = 0; i_addr = BASE + off; i_wdata = '0; i_wstrb = '0;
  endtask

  task automatic set_wr(input logic [63:0] off, input logic [63:0] data, input logic [7:0] strb);
    i_valid = 1; i_wen = 1; i_addr = BASE + off; i_wdata = data; i_wstrb = strb;
  endtask

  logic [63:0] offs [12] = '{64'h0, 64'h4, 64'h8, 64'h2, 64'h4000, 64'h4008, 64'h4010,
                             64'h4004, 64'hBFF8, 64'hBFFC, 64'h10000, 64'hFFFF_FFFF_FFFF_FFF8};

  initial begin
    bit synced;
    rst_n = 0;
    set_idle();
    repeat (3) cycle();
    check("reset_rdata", rdata_o[0], 64'h0);
    check("reset_tint", 64'(tint_o[1]), 64'h0);

    // Reset release: mtime read at fifth cycle, mtimecmp[1] = 20 reached on the div-4 instance.
    rst_n = 1;
    for (int n = 1; n <= 81; n++) begin
      if (n == 1)      set_wr(64'h4008, 64'd20, 8'hFF);
      else if (n == 5) set_rd(64'hBFF8);
      else             set_idle();
      cycle();
      if (n == 5) begin
        check("mtime_at_5", rdata_o[0], 64'd4);
        check("rvalid_at_5", 64'(rvalid_o[0]), 64'd1);
        check("tint_at_5", 64'(tint_o[0]), 64'd0);
      end
      if (n == 80) check("div4_tint1_before", 64'(tint_o[1][1]), 64'd0);
      if (n == 81) begin
        check("div4_tint1_rise", 64'(tint_o[1][1]), 64'd1);
        check("div4_tint0_low", 64'(tint_o[1][0]), 64'd0);
      end
    end

    // mtime wrap on the div-1 instance.
    set_wr(64'hBFF8, 64'hFFFF_FFFF_FFFF_FFFE, 8'hFF); cycle();
    set_idle(); cycle();
    cycle();
    check("wrap_tint0_high", 64'(tint_o[0][0]), 64'd1);
    set_rd(64'hBFF8); cycle();
    check("wrap_tint0_drop", 64'(tint_o[0][0]), 64'd0);
    check("wrap_mtime_zero", rdata_o[0], 64'd0);

    // msip[1] through the upper lane.
    set_wr(64'h4, 64'h1_0000_0000, 8'hF0); cycle();
    check("soft1_latency", 64'(soft_o[0][1]), 64'd0);
    set_idle(); cycle();
    check("soft1_set", 64'(soft_o[0][1]), 64'd1);
    set_rd(64'h4); cycle();
    check("msip1_readback", rdata_o[0], 64'h1_0000_0000);

    // Partial write to mtimecmp[0].
    set_wr(64'h4000, 64'hAAAA_BBBB_CCCC_DDDD, 8'hFF); cycle();
    set_wr(64'h4000, 64'h1234_5678, 8'h0F); cycle();
    set_rd(64'h4000); cycle();
    check("cmp0_partial", rdata_o[0], 64'hAAAA_BBBB_1234_5678);

    // mtime write landing on the div-4 prescaler wrap cycle.
    synced = 0;
    for (int i = 0; i < 8; i++) begin
      if (m_presc[1] == 3) begin synced = 1; break; end
      set_idle(); cycle();
    end
    check("presc_sync", 64'(synced), 64'd1);
    set_wr(64'hBFF8, 64'h100, 8'hFF); cycle();
    for (int n = 1; n <= 5; n++) begin
      set_rd(64'hBFF8); cycle();
      if (n == 1) check("wrwrap_written", rdata_o[1], 64'h100);
      if (n == 4) check("wrwrap_hold", rdata_o[1], 64'h100);
      if (n == 5) check("wrwrap_restart", rdata_o[1], 64'h101);
    end

    // Unmapped read.
    set_rd(64'h8000); cycle();
    for (int k = 0; k < 2; k++) begin
      check("unmapped_rdata", rdata_o[k], 64'h0);
      check("unmapped_rvalid", 64'(rvalid_o[k]), 64'd1);
      check("unmapped_err", 64'(err_o[k]), 64'd1);
    end

    // Read issued while reset is asserted is dropped.
    rst_n = 0; set_rd(64'hBFF8); cycle();
    check("reset_drops_rvalid", 64'(rvalid_o[0]), 64'd0);
    rst_n = 1; set_idle(); cycle();

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      rst_n   = ($urandom_range(0, 199) != 0);
      i_valid = ($urandom_range(0, 3) != 0);
      i_wen   = $urandom_range(0, 1);
      i_addr  = BASE + offs[$urandom_range(0, 11)];
      if ($urandom_range(0, 3) == 0) i_addr[1:0] = 2'($urandom_range(0, 3));
      i_wdata = ($urandom_range(0, 1) != 0) ? 64'($urandom_range(0, 300))
                                            : {32'($urandom), 32'($urandom)};
      i_wstrb = ($urandom_range(0, 1) != 0) ? 8'hFF : 8'($urandom);
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
